// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX back-pressure hold and flush.
// Optional bubble counter enabled by defining HAZARD_CNT_EN; otherwise bubble_cnt is tied to 0.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [10:0]       id_ctrl,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [10:0]       ex_ctrl,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_wr_reg,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic       uses_rt;
    logic       rs_match;
    logic       rt_match;
    logic       load_use;
    logic [4:0] id_wr_reg;

    // R-type, branch and store read rt; immediate-form loads/ALU ops do not.
    assign uses_rt   = ~id_ctrl[2] | id_ctrl[7];
    assign rs_match  = (ex_wr_reg == id_rs);
    assign rt_match  = uses_rt & (ex_wr_reg == id_rt);
    assign load_use  = ex_valid & ex_ctrl[8] & (ex_wr_reg != 5'd0) & id_valid
                     & (rs_match | rt_match);
    assign stall_id  = (load_use | ex_stall) & ~flush;
    assign id_wr_reg = id_ctrl[0] ? id_rd : id_rt;

    // Priority: reset, flush bubble, EX hold, load-use bubble, normal load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_wr_reg  <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_pc4     <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (ex_stall) begin
            ex_valid <= ex_valid;
        end else if (load_use) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid   <= id_valid;
            ex_ctrl    <= id_valid ? id_ctrl : 11'd0;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_wr_reg  <= id_wr_reg;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_pc4     <= id_pc4;
        end
    end

`ifdef HAZARD_CNT_EN
    logic [CNT_W-1:0] bubble_q;
    logic             bubble_taken;

    // Counts only bubbles actually inserted for load-use, saturating at all-ones.
    assign bubble_taken = ~flush & ~ex_stall & load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= '0;
        end else if (bubble_taken && !(&bubble_q)) begin
            bubble_q <= bubble_q + CNT_W'(1);
        end
    end

    assign bubble_cnt = bubble_q;
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, load, load-use, stall, flush.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
`ifdef HAZARD_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [10:0] CTRL_RTYPE = 11'h023;
    localparam logic [10:0] CTRL_ADDI  = 11'h006;
    localparam logic [10:0] CTRL_LW    = 11'h146;
    localparam logic [10:0] CTRL_SW    = 11'h084;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [10:0]       id_ctrl;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
    logic              ex_stall, flush;
    logic              stall_id, ex_valid;
    logic [10:0]       ex_ctrl;
    logic [4:0]        ex_rs, ex_rt, ex_wr_reg;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [CNT_W-1:0]  bubble_cnt;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4),
        .ex_stall(ex_stall), .flush(flush), .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_ctrl(ex_ctrl), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wr_reg(ex_wr_reg),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [10:0] c, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] rtd,
                                 input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] pc4);
        id_valid   = v;
        id_ctrl    = c;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_rs_data = rsd;
        id_rt_data = rtd;
        id_imm     = imm;
        id_pc4     = pc4;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ex_stall = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b0, 11'd0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0);
        stepCycle();
        stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("reset_ex_valid", ex_valid, 0);
        checkOutput("reset_ex_ctrl", ex_ctrl, 0);
        checkOutput("reset_ex_wr_reg", ex_wr_reg, 0);
        checkOutput("reset_ex_rs_data", ex_rs_data, 0);
        checkOutput("reset_ex_pc4", ex_pc4, 0);
        checkOutput("reset_bubble_cnt", bubble_cnt, 0);
        checkOutput("reset_stall_id", stall_id, 0);

        // R-type with RegDst=1 writes rd
        applyStimulus(1'b1, CTRL_RTYPE, 5'd1, 5'd2, 5'd3, 32'h1111_1111, 32'h2222_2222,
                      32'h0000_0033, 32'h0000_0100);
        checkOutput("rtype_stall_id", stall_id, 0);
        stepCycle();
        checkOutput("rtype_ex_valid", ex_valid, 1);
        checkOutput("rtype_ex_ctrl", ex_ctrl, 12'h023);
        checkOutput("rtype_ex_wr_reg", ex_wr_reg, 3);
        checkOutput("rtype_ex_rs", ex_rs, 1);
        checkOutput("rtype_ex_rt", ex_rt, 2);
        checkOutput("rtype_ex_rs_data", ex_rs_data, 32'h1111_1111);
        checkOutput("rtype_ex_rt_data", ex_rt_data, 32'h2222_2222);
        checkOutput("rtype_ex_imm", ex_imm, 32'h33);
        checkOutput("rtype_ex_pc4", ex_pc4, 32'h100);

        // Invalid ID slot loads as an empty EX slot
        applyStimulus(1'b0, CTRL_RTYPE, 5'd1, 5'd2, 5'd3, '0, '0, '0, 32'h104);
        stepCycle();
        checkOutput("invalid_ex_valid", ex_valid, 0);
        checkOutput("invalid_ex_ctrl", ex_ctrl, 0);

        // lw r5 then dependent add on rs
        applyStimulus(1'b1, CTRL_LW, 5'd1, 5'd5, 5'd0, 32'hA, 32'hB, 32'h4, 32'h108);
        stepCycle();
        checkOutput("lw_ex_wr_reg", ex_wr_reg, 5);
        checkOutput("lw_ex_ctrl", ex_ctrl, 12'h146);
        applyStimulus(1'b1, CTRL_RTYPE, 5'd5, 5'd2, 5'd6, 32'hC, 32'hD, 32'h0, 32'h10C);
        checkOutput("lu_rs_stall_id", stall_id, 1);
        stepCycle();
        checkOutput("lu_bubble_ex_valid", ex_valid, 0);
        checkOutput("lu_bubble_ex_ctrl", ex_ctrl, 0);
        checkOutput("lu_bubble_cnt", bubble_cnt, CNT_EN ? 1 : 0);
        checkOutput("lu_cleared_stall_id", stall_id, 0);
        stepCycle();
        checkOutput("lu_reload_ex_valid", ex_valid, 1);
        checkOutput("lu_reload_ex_ctrl", ex_ctrl, 12'h023);
        checkOutput("lu_reload_ex_wr_reg", ex_wr_reg, 6);
        checkOutput("lu_reload_ex_pc4", ex_pc4, 32'h10C);

        // lw to $zero never hazards
        applyStimulus(1'b1, CTRL_LW, 5'd1, 5'd0, 5'd0, '0, '0, '0, 32'h110);
        stepCycle();
        applyStimulus(1'b1, CTRL_RTYPE, 5'd0, 5'd7, 5'd8, '0, '0, '0, 32'h114);
        checkOutput("zero_dest_stall_id", stall_id, 0);
        stepCycle();
        checkOutput("zero_dest_ex_valid", ex_valid, 1);

        // addi does not read rt, store does
        applyStimulus(1'b1, CTRL_LW, 5'd1, 5'd5, 5'd0, '0, '0, '0, 32'h118);
        stepCycle();
        applyStimulus(1'b1, CTRL_ADDI, 5'd1, 5'd5, 5'd9, '0, '0, 32'h7, 32'h11C);
        checkOutput("addi_rt_stall_id", stall_id, 0);
        applyStimulus(1'b1, CTRL_SW, 5'd1, 5'd5, 5'd9, 32'h55, 32'h66, 32'h8, 32'h11C);
        checkOutput("sw_rt_stall_id", stall_id, 1);
        stepCycle();
        checkOutput("sw_bubble_ex_valid", ex_valid, 0);
        checkOutput("sw_bubble_cnt", bubble_cnt, CNT_EN ? 2 : 0);
        stepCycle();
        checkOutput("sw_ex_ctrl", ex_ctrl, 12'h084);
        checkOutput("sw_ex_wr_reg", ex_wr_reg, 5);

        // EX back-pressure holds every EX register
        ex_stall = 1'b1;
        applyStimulus(1'b1, CTRL_RTYPE, 5'd10, 5'd11, 5'd12, 32'h77, 32'h88, 32'h9, 32'h120);
        checkOutput("stall_stall_id", stall_id, 1);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("stall_hold_ex_valid", ex_valid, 1);
            checkOutput("stall_hold_ex_ctrl", ex_ctrl, 12'h084);
            checkOutput("stall_hold_ex_rt_data", ex_rt_data, 32'h66);
            checkOutput("stall_hold_ex_pc4", ex_pc4, 32'h11C);
        end
        ex_stall = 1'b0;
        #1;
        checkOutput("unstall_stall_id", stall_id, 0);
        stepCycle();
        checkOutput("unstall_ex_ctrl", ex_ctrl, 12'h023);
        checkOutput("unstall_ex_wr_reg", ex_wr_reg, 12);
        checkOutput("unstall_ex_rs_data", ex_rs_data, 32'h77);

        // Flush beats both stall sources and does not count a bubble
        applyStimulus(1'b1, CTRL_LW, 5'd1, 5'd5, 5'd0, '0, '0, '0, 32'h124);
        stepCycle();
        ex_stall = 1'b1;
        flush = 1'b1;
        applyStimulus(1'b1, CTRL_RTYPE, 5'd5, 5'd2, 5'd6, '0, '0, '0, 32'h128);
        checkOutput("flush_stall_id", stall_id, 0);
        stepCycle();
        checkOutput("flush_ex_valid", ex_valid, 0);
        checkOutput("flush_ex_ctrl", ex_ctrl, 0);
        checkOutput("flush_bubble_cnt", bubble_cnt, CNT_EN ? 2 : 0);
        ex_stall = 1'b0;
        flush = 1'b0;

        // Reset during a load-use stall empties the stage
        applyStimulus(1'b1, CTRL_LW, 5'd1, 5'd5, 5'd0, '0, '0, '0, 32'h12C);
        stepCycle();
        applyStimulus(1'b1, CTRL_RTYPE, 5'd5, 5'd2, 5'd6, '0, '0, '0, 32'h130);
        checkOutput("prerst_stall_id", stall_id, 1);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("midrst_ex_valid", ex_valid, 0);
        checkOutput("midrst_stall_id", stall_id, 0);
        checkOutput("midrst_bubble_cnt", bubble_cnt, 0);
        checkOutput("midrst_ex_pc4", ex_pc4, 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
